ctrl_pipeline: RTL and testbench
================================

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 Parameter REG_W, default 3, register address width.
REQ-002 Parameter MEM_LAT, default 1, number of MEM stages, legal 1..4.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 id_valid  in  1  decode slot holds an instruction.
REQ-006 id_opcode  in  5 and id_funct  in  2  instruction opcode and R-format function field.
REQ-007 id_dest, id_rs, id_rt  in  REG_W each  write register (upstream-muxed) and source registers.
REQ-008 stall_in  in  1  external freeze (memory busy); flush  in  1  taken branch/jump resolved in EX.
REQ-009 id_stall  out  1  decode/fetch must hold the current instruction.
REQ-010 ex_valid, ex_aluOp[2:0], ex_invA, ex_invB, ex_cin, ex_aluSrc[1:0], ex_zeroExt, ex_brControl[1:0], ex_jump  out  EX-stage control.
REQ-011 mem_valid, mem_read, mem_write  out  1 each  control of the last MEM stage.
REQ-012 wb_valid, wb_regWrite, wb_memToReg  out  1 each; wb_dest  out  REG_W  writeback control.
REQ-013 halted  out  1  sticky halt indicator.

Function
REQ-014 Decode SHALL be a full case over all 32 opcodes; every output bit SHALL be a defined 0/1 (no x) for every opcode.
REQ-015 Immediate arithmetic 010xx: aluSrc=10, zeroExt=opcode[2], regWrite=1; xx=00 add; 01 subtract (invA=cin=1, aluOp=000); 10 aluOp=010; 11 aluOp=011 with invB=1.
REQ-016 Immediate shift 101xx: aluSrc=10, aluOp={1,xx}, regWrite=1; R-format 11011 and 11010 SHALL use id_funct in place of xx with the same rules as REQ-015/016, aluSrc=00.
REQ-017 LD 10001: memRead=1, memToReg=1, regWrite=1; ST 10000: memWrite=1, regWrite=0; STU 10011: memWrite=1, regWrite=1; all three aluSrc=10, aluOp=000.
REQ-018 Branch 011xx: brControl=xx, regWrite=0; set 111xx: aluSrc=11, regWrite=1; jumps 001xx: jump=1, regWrite=opcode[1]; NOP, HALT, 00010, 00011: all controls 0.
REQ-019 Pipeline: ID -> EX -> MEM_1..MEM_LAT -> WB, one register stage each; decoded control of an accepted instruction SHALL appear on EX outputs 1 cycle after acceptance, on mem_* MEM_LAT cycles later, on wb_* 1 cycle after that.
REQ-020 An instruction is accepted when id_valid=1 and id_stall=0.
REQ-021 Hazard: id_stall=1 when the ID instruction reads a source (rs for all except 00xxx/11000; rt for 11011, 11010, 111xx, 10000, 10011) equal to the dest of any valid regWrite=1 instruction in EX or any MEM stage.
REQ-022 On hazard without stall_in: EX loads a bubble (valid=0, all controls 0); MEM and WB stages advance.
REQ-023 stall_in=1: all stages hold, id_stall=1, except as modified by REQ-024.
REQ-024 flush=1: EX loads a bubble and the ID instruction is not accepted, regardless of hazard or stall_in; older stages advance unless stall_in=1.
REQ-025 Controls of stages whose valid=0 SHALL read 0 on outputs.
REQ-026 halted SHALL set in the cycle after a valid HALT is in WB and stay 1 until rst; after HALT is accepted, id_stall=1 until rst.

Reset
REQ-027 rst=1 SHALL clear every stage valid bit and control field to 0, halted=0, id_stall=0 on the following cycle; rst dominates stall_in and flush.
REQ-028 Reset mid-operation SHALL discard all in-flight instructions with no write or memory side effect after the reset edge.

Structure
REQ-029 Opcode constants, ALU-op encodings and the control-bundle field widths SHALL reside in a shared package ctrl_pkg.
REQ-030 The combinational opcode-to-control table SHALL be a sub-module ctrl_decode; the stage registers and hazard logic live in ctrl_pipeline.

Verification
REQ-031 ADDI then XOR reading its dest, MEM_LAT=1 -> id_stall=1 for 2 cycles, 2 EX bubbles, XOR issues on cycle 3.
REQ-032 LD r1; ST using r1 as rt; MEM_LAT=3 -> 4 stall cycles; mem_read=1 observed 4 cycles after LD issue.
REQ-033 SUBI decode -> ex_aluOp=000, ex_invA=1, ex_cin=1, ex_aluSrc=10 one cycle after acceptance.
REQ-034 flush=1 together with stall_in=1 and hazard -> ex_valid=0 next cycle; MEM/WB unchanged.
REQ-035 HALT accepted, MEM_LAT=2 -> halted=1 exactly 5 cycles later; further id_valid ignored; rst clears halted.
REQ-036 rst asserted with LD in MEM -> mem_read=0 and wb_valid=0 on all following cycles.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU-op and control-bundle definitions
// for the control pipeline and its decoder.
package ctrl_pkg;

  localparam int OP_W = 5;

  localparam logic [4:0] OP_HALT   = 5'b00000;
  localparam logic [4:0] OP_NOP    = 5'b00001;
  localparam logic [4:0] OP_ST     = 5'b10000;
  localparam logic [4:0] OP_LD     = 5'b10001;
  localparam logic [4:0] OP_STU    = 5'b10011;
  localparam logic [4:0] OP_RSHIFT = 5'b11010;
  localparam logic [4:0] OP_RARITH = 5'b11011;
  localparam logic [4:0] OP_SRCLESS = 5'b11000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_ANDN = 3'b011;

  localparam logic [1:0] SRC_REG = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b10;
  localparam logic [1:0] SRC_SET = 2'b11;

  typedef struct packed {
    logic [2:0] aluOp;
    logic       invA;
    logic       invB;
    logic       cin;
    logic [1:0] aluSrc;
    logic       zeroExt;
    logic [1:0] brControl;
    logic       jump;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       memToReg;
    logic       halt;
  } ctrl_t;

  function automatic ctrl_t aluArith(input logic [1:0] sel);
    ctrl_t c;
    c = '0;
    unique case (sel)
      2'b00: c.aluOp = ALU_ADD;
      2'b01: begin
        c.aluOp = ALU_ADD;
        c.invA  = 1'b1;
        c.cin   = 1'b1;
      end
      2'b10: c.aluOp = ALU_XOR;
      default: begin
        c.aluOp = ALU_ANDN;
        c.invB  = 1'b1;
      end
    endcase
    return c;
  endfunction

  function automatic ctrl_t aluShift(input logic [1:0] sel);
    ctrl_t c;
    c = '0;
    c.aluOp = {1'b1, sel};
    return c;
  endfunction

  // 00xxx and 11000 carry no rs operand
  function automatic logic readsRs(input logic [4:0] op);
    return (op[4:3] != 2'b00) && (op != OP_SRCLESS);
  endfunction

  function automatic logic readsRt(input logic [4:0] op);
    return (op == OP_RARITH) || (op == OP_RSHIFT) ||
           (op == OP_ST) || (op == OP_STU) ||
           (op[4:2] == 3'b111);
  endfunction

endpackage

// File: rtl/ctrl_pipeline_decode.sv
// Combinational opcode-to-control table.
// Unlisted opcodes decode to an all-zero bundle.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [1:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique casez (opcode)
      5'b010??: begin
        ctrl          = aluArith(opcode[1:0]);
        ctrl.aluSrc   = SRC_IMM;
        ctrl.zeroExt  = opcode[2];
        ctrl.regWrite = 1'b1;
      end
      5'b101??: begin
        ctrl          = aluShift(opcode[1:0]);
        ctrl.aluSrc   = SRC_IMM;
        ctrl.regWrite = 1'b1;
      end
      OP_RARITH: begin
        ctrl          = aluArith(funct);
        ctrl.aluSrc   = SRC_REG;
        ctrl.regWrite = 1'b1;
      end
      OP_RSHIFT: begin
        ctrl          = aluShift(funct);
        ctrl.aluSrc   = SRC_REG;
        ctrl.regWrite = 1'b1;
      end
      OP_LD: begin
        ctrl.aluSrc   = SRC_IMM;
        ctrl.memRead  = 1'b1;
        ctrl.memToReg = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      OP_ST: begin
        ctrl.aluSrc   = SRC_IMM;
        ctrl.memWrite = 1'b1;
      end
      OP_STU: begin
        ctrl.aluSrc   = SRC_IMM;
        ctrl.memWrite = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      5'b011??: ctrl.brControl = opcode[1:0];
      5'b111??: begin
        ctrl.aluSrc   = SRC_SET;
        ctrl.regWrite = 1'b1;
      end
      5'b001??: begin
        ctrl.jump     = 1'b1;
        ctrl.regWrite = opcode[1];
      end
      OP_HALT: ctrl.halt = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control pipeline: ID -> EX -> MEM_1..MEM_LAT -> WB
// stage registers with load-use hazard and halt handling.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int REG_W   = 3,
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_opcode,
  input  logic [1:0]       id_funct,
  input  logic [REG_W-1:0] id_dest,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             stall_in,
  input  logic             flush,
  output logic             id_stall,
  output logic             ex_valid,
  output logic [2:0]       ex_aluOp,
  output logic             ex_invA,
  output logic             ex_invB,
  output logic             ex_cin,
  output logic [1:0]       ex_aluSrc,
  output logic             ex_zeroExt,
  output logic [1:0]       ex_brControl,
  output logic             ex_jump,
  output logic             mem_valid,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_valid,
  output logic             wb_regWrite,
  output logic             wb_memToReg,
  output logic [REG_W-1:0] wb_dest,
  output logic             halted
);

  // index 0 = EX, 1..MEM_LAT = MEM, MEM_LAT+1 = WB
  localparam int NST = MEM_LAT + 2;
  localparam int LM  = MEM_LAT;
  localparam int LW  = MEM_LAT + 1;

  ctrl_t decCtrl;
  logic [NST-1:0] stValid;
  ctrl_t [NST-1:0] stCtrl;
  logic [NST-1:0][REG_W-1:0] stDest;
  logic haltSeen;
  logic hazard;
  logic accept;

  ctrl_decode uDec (
    .opcode(id_opcode),
    .funct (id_funct),
    .ctrl  (decCtrl)
  );

  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s <= LM; s++) begin
      if (id_valid && stValid[s] && stCtrl[s].regWrite &&
          ((readsRs(id_opcode) && stDest[s] == id_rs) ||
           (readsRt(id_opcode) && stDest[s] == id_rt)))
        hazard = 1'b1;
    end
  end

  assign id_stall = haltSeen | stall_in | flush | hazard;
  assign accept   = id_valid & ~id_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      stValid  <= '0;
      stCtrl   <= '0;
      stDest   <= '0;
      haltSeen <= 1'b0;
      halted   <= 1'b0;
    end else begin
      if (stValid[LW] && stCtrl[LW].halt)
        halted <= 1'b1;
      if (accept && decCtrl.halt)
        haltSeen <= 1'b1;
      // flush squashes EX even while the rest is frozen
      if (flush || !stall_in) begin
        stValid[0] <= accept;
        stCtrl[0]  <= accept ? decCtrl : '0;
        stDest[0]  <= accept ? id_dest : '0;
      end
      if (!stall_in) begin
        for (int s = 1; s < NST; s++) begin
          stValid[s] <= stValid[s-1];
          stCtrl[s]  <= stCtrl[s-1];
          stDest[s]  <= stDest[s-1];
        end
      end
    end
  end

  assign ex_valid     = stValid[0];
  assign ex_aluOp     = stValid[0] ? stCtrl[0].aluOp : '0;
  assign ex_invA      = stValid[0] & stCtrl[0].invA;
  assign ex_invB      = stValid[0] & stCtrl[0].invB;
  assign ex_cin       = stValid[0] & stCtrl[0].cin;
  assign ex_aluSrc    = stValid[0] ? stCtrl[0].aluSrc : '0;
  assign ex_zeroExt   = stValid[0] & stCtrl[0].zeroExt;
  assign ex_brControl = stValid[0] ? stCtrl[0].brControl : '0;
  assign ex_jump      = stValid[0] & stCtrl[0].jump;

  assign mem_valid = stValid[LM];
  assign mem_read  = stValid[LM] & stCtrl[LM].memRead;
  assign mem_write = stValid[LM] & stCtrl[LM].memWrite;

  assign wb_valid    = stValid[LW];
  assign wb_regWrite = stValid[LW] & stCtrl[LW].regWrite;
  assign wb_memToReg = stValid[LW] & stCtrl[LW].memToReg;
  assign wb_dest     = stValid[LW] ? stDest[LW] : '0;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: three instances (MEM_LAT 1..3)
// share one input stream and are checked against a slot model.
module tb_ctrl_pipeline;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic idValid = 1'b0;
  logic [4:0] idOp = '0;
  logic [1:0] idFunct = '0;
  logic [2:0] idDest = '0;
  logic [2:0] idRs = '0;
  logic [2:0] idRt = '0;
  logic stallIn = 1'b0;
  logic flush = 1'b0;

  typedef struct packed {
    logic       idStall;
    logic       exValid;
    logic [2:0] exAluOp;
    logic       exInvA;
    logic       exInvB;
    logic       exCin;
    logic [1:0] exAluSrc;
    logic       exZeroExt;
    logic [1:0] exBr;
    logic       exJump;
    logic       memValid;
    logic       memRead;
    logic       memWrite;
    logic       wbValid;
    logic       wbRegWrite;
    logic       wbMemToReg;
    logic [2:0] wbDest;
    logic       halted;
  } obs_t;

  obs_t obs [3];

  for (genvar g = 0; g < 3; g++) begin : gi
    logic idStall, exValid, exInvA, exInvB, exCin;
    logic exZeroExt, exJump, memValid, memRead, memWrite;
    logic wbValid, wbRegWrite, wbMemToReg, halted;
    logic [2:0] exAluOp, wbDest;
    logic [1:0] exAluSrc, exBr;

    ctrl_pipeline #(.REG_W(3), .MEM_LAT(g + 1)) dut (
      .clk(clk), .rst(rst), .id_valid(idValid),
      .id_opcode(idOp), .id_funct(idFunct), .id_dest(idDest),
      .id_rs(idRs), .id_rt(idRt), .stall_in(stallIn), .flush(flush),
      .id_stall(idStall), .ex_valid(exValid), .ex_aluOp(exAluOp),
      .ex_invA(exInvA), .ex_invB(exInvB), .ex_cin(exCin),
      .ex_aluSrc(exAluSrc), .ex_zeroExt(exZeroExt),
      .ex_brControl(exBr), .ex_jump(exJump),
      .mem_valid(memValid), .mem_read(memRead), .mem_write(memWrite),
      .wb_valid(wbValid), .wb_regWrite(wbRegWrite),
      .wb_memToReg(wbMemToReg), .wb_dest(wbDest), .halted(halted)
    );

    assign obs[g] = {idStall, exValid, exAluOp, exInvA, exInvB, exCin,
                     exAluSrc, exZeroExt, exBr, exJump,
                     memValid, memRead, memWrite,
                     wbValid, wbRegWrite, wbMemToReg, wbDest, halted};
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op,
                       input logic [1:0] fn, input logic [2:0] d,
                       input logic [2:0] rs, input logic [2:0] rt);
    idValid = v;
    idOp    = op;
    idFunct = fn;
    idDest  = d;
    idRs    = rs;
    idRt    = rt;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 2'd0, 3'd0, 3'd0, 3'd0);
    stallIn = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic doReset();
    idle();
    rst = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0] aluOp;
    logic       invA, invB, cin;
    logic [1:0] src;
    logic       zx;
    logic [1:0] br;
    logic       jmp, mr, mw, rw, m2r;
  } mctl_t;

  typedef struct packed {
    logic       v;
    logic [4:0] op;
    logic [1:0] fn;
    logic [2:0] d;
  } slot_t;

  slot_t pipe [3][6];
  bit mHaltSeen [3];
  bit mHalted [3];

  function automatic mctl_t mdec(input logic [4:0] op, input logic [1:0] fn);
    mctl_t c;
    logic [1:0] xx;
    bit immAr, immSh, rAr, rSh;
    c = '0;
    immAr = (op[4:2] == 3'b010);
    immSh = (op[4:2] == 3'b101);
    rAr = (op == 5'd27);
    rSh = (op == 5'd26);
    xx = (rAr || rSh) ? fn : op[1:0];
    if (immAr || rAr) begin
      c.aluOp = (xx < 2) ? 3'b000 : {1'b0, xx};
      c.invA = (xx == 2'd1);
      c.cin = (xx == 2'd1);
      c.invB = (xx == 2'd3);
      c.rw = 1'b1;
      c.src = immAr ? 2'b10 : 2'b00;
      c.zx = immAr && op[2];
    end else if (immSh || rSh) begin
      c.aluOp = {1'b1, xx};
      c.rw = 1'b1;
      c.src = immSh ? 2'b10 : 2'b00;
    end else if (op == 5'd17) begin
      c.mr = 1'b1; c.m2r = 1'b1; c.rw = 1'b1; c.src = 2'b10;
    end else if (op == 5'd16) begin
      c.mw = 1'b1; c.src = 2'b10;
    end else if (op == 5'd19) begin
      c.mw = 1'b1; c.rw = 1'b1; c.src = 2'b10;
    end else if (op[4:2] == 3'b011) begin
      c.br = op[1:0];
    end else if (op[4:2] == 3'b111) begin
      c.src = 2'b11; c.rw = 1'b1;
    end else if (op[4:2] == 3'b001) begin
      c.jmp = 1'b1; c.rw = op[1];
    end
    return c;
  endfunction

  function automatic bit mStall(input int i);
    bit haz, rdRs, rdRt;
    mctl_t c;
    haz = 0;
    rdRs = (idOp[4:3] != 2'b00) && (idOp != 5'd24);
    rdRt = (idOp == 5'd27) || (idOp == 5'd26) || (idOp == 5'd16) ||
           (idOp == 5'd19) || (idOp[4:2] == 3'b111);
    for (int s = 0; s <= i + 1; s++) begin
      c = mdec(pipe[i][s].op, pipe[i][s].fn);
      if (pipe[i][s].v && c.rw &&
          ((rdRs && pipe[i][s].d == idRs) || (rdRt && pipe[i][s].d == idRt)))
        haz = 1;
    end
    return mHaltSeen[i] || stallIn || flush || (idValid && haz);
  endfunction

  function automatic obs_t expectOf(input int i, input bit st);
    obs_t e;
    mctl_t c;
    slot_t ex, mm, wb;
    ex = pipe[i][0];
    mm = pipe[i][i + 1];
    wb = pipe[i][i + 2];
    e = '0;
    e.idStall = st;
    if (ex.v) begin
      c = mdec(ex.op, ex.fn);
      e.exValid = 1; e.exAluOp = c.aluOp; e.exInvA = c.invA;
      e.exInvB = c.invB; e.exCin = c.cin; e.exAluSrc = c.src;
      e.exZeroExt = c.zx; e.exBr = c.br; e.exJump = c.jmp;
    end
    if (mm.v) begin
      c = mdec(mm.op, mm.fn);
      e.memValid = 1; e.memRead = c.mr; e.memWrite = c.mw;
    end
    if (wb.v) begin
      c = mdec(wb.op, wb.fn);
      e.wbValid = 1; e.wbRegWrite = c.rw; e.wbMemToReg = c.m2r;
      e.wbDest = wb.d;
    end
    e.halted = mHalted[i];
    return e;
  endfunction

  task automatic mStep(input int i);
    bit st, acc;
    slot_t nw;
    if (rst) begin
      for (int s = 0; s < 6; s++) pipe[i][s] = '0;
      mHaltSeen[i] = 0;
      mHalted[i] = 0;
      return;
    end
    if (pipe[i][i + 2].v && pipe[i][i + 2].op == 5'd0) mHalted[i] = 1;
    st = mStall(i);
    acc = idValid && !st;
    if (acc && idOp == 5'd0) mHaltSeen[i] = 1;
    nw = acc ? {1'b1, idOp, idFunct, idDest} : '0;
    if (!stallIn) begin
      for (int s = i + 2; s >= 1; s--) pipe[i][s] = pipe[i][s - 1];
      pipe[i][0] = nw;
    end else if (flush) begin
      pipe[i][0] = nw;
    end
  endtask

  // ---------------- decode vectors ----------------
  typedef struct {
    logic [4:0]  op;
    logic [1:0]  fn;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl [14];

  initial begin
    obs_t e;
    logic [12:0] act;
    logic [4:0] op;

    // exp = {aluOp, invA, invB, cin, aluSrc, zeroExt, brControl, jump}
    tbl[0]  = '{5'b01000, 2'b00, 13'b000_000_10_0_00_0};
    tbl[1]  = '{5'b01001, 2'b00, 13'b000_101_10_0_00_0};
    tbl[2]  = '{5'b01010, 2'b00, 13'b010_000_10_0_00_0};
    tbl[3]  = '{5'b01011, 2'b00, 13'b011_010_10_0_00_0};
    tbl[4]  = '{5'b10100, 2'b00, 13'b100_000_10_0_00_0};
    tbl[5]  = '{5'b10111, 2'b00, 13'b111_000_10_0_00_0};
    tbl[6]  = '{5'b11011, 2'b01, 13'b000_101_00_0_00_0};
    tbl[7]  = '{5'b11011, 2'b11, 13'b011_010_00_0_00_0};
    tbl[8]  = '{5'b11010, 2'b10, 13'b110_000_00_0_00_0};
    tbl[9]  = '{5'b10001, 2'b00, 13'b000_000_10_0_00_0};
    tbl[10] = '{5'b01110, 2'b00, 13'b000_000_00_0_10_0};
    tbl[11] = '{5'b11101, 2'b00, 13'b000_000_11_0_00_0};
    tbl[12] = '{5'b00110, 2'b00, 13'b000_000_00_0_00_1};
    tbl[13] = '{5'b00001, 2'b00, 13'b000_000_00_0_00_0};

    doReset();
    for (int g = 0; g < 3; g++)
      chk($sformatf("reset state dut%0d", g), obs[g], 0);

    for (int i = 0; i < 14; i++) begin
      drive(1'b1, tbl[i].op, tbl[i].fn, 3'd0, 3'd1, 3'd1);
      nextCycle();
      idle();
      #1;
      act = {obs[0].exAluOp, obs[0].exInvA, obs[0].exInvB, obs[0].exCin,
             obs[0].exAluSrc, obs[0].exZeroExt, obs[0].exBr, obs[0].exJump};
      chk($sformatf("decode op%05b valid", tbl[i].op), obs[0].exValid, 1);
      chk($sformatf("decode op%05b fields", tbl[i].op), act, tbl[i].exp);
    end

    // every opcode decodes to defined values; HALT last
    for (int k = 1; k <= 32; k++) begin
      op = 5'(k);
      drive(1'b1, op, 2'b10, 3'd0, 3'd1, 3'd1);
      nextCycle();
      idle();
      #1;
      chk($sformatf("no-x op%05b", op), {31'd0, $isunknown(obs[0])}, 0);
    end

    // ADDI r1 then XOR reading r1, MEM_LAT=1
    doReset();
    drive(1'b1, 5'b01000, 2'b00, 3'd1, 3'd2, 3'd3);
    #1 chk("addi accept", obs[0].idStall, 0);
    nextCycle();
    drive(1'b1, 5'b11011, 2'b10, 3'd4, 3'd1, 3'd2);
    #1 chk("raw c1 stall", obs[0].idStall, 1);
    chk("raw c1 ex addi", obs[0].exValid, 1);
    nextCycle();
    #1 chk("raw c2 stall", obs[0].idStall, 1);
    chk("raw c2 bubble", obs[0].exValid, 0);
    nextCycle();
    #1 chk("raw c3 issue", obs[0].idStall, 0);
    chk("raw c3 bubble", obs[0].exValid, 0);
    nextCycle();
    idle();
    #1 chk("raw c4 xor ex", {obs[0].exValid, obs[0].exAluOp}, 4'b1010);

    // LD r1 then ST with rt=r1, MEM_LAT=3
    doReset();
    drive(1'b1, 5'b10001, 2'b00, 3'd1, 3'd2, 3'd2);
    #1 chk("ld accept", obs[2].idStall, 0);
    for (int k = 1; k <= 5; k++) begin
      nextCycle();
      drive(1'b1, 5'b10000, 2'b00, 3'd0, 3'd2, 3'd1);
      #1;
      chk($sformatf("ld-st stall c%0d", k), obs[2].idStall, (k <= 4));
      chk($sformatf("ld mem_read c%0d", k), obs[2].memRead, (k == 4));
    end
    nextCycle();
    idle();
    #1 chk("st in ex", {obs[2].exValid, obs[2].exAluSrc}, 3'b110);

    // flush with stall_in and hazard
    doReset();
    drive(1'b1, 5'b01000, 2'b00, 3'd5, 3'd0, 3'd0);
    nextCycle();
    drive(1'b1, 5'b10001, 2'b00, 3'd1, 3'd2, 3'd2);
    nextCycle();
    drive(1'b1, 5'b01000, 2'b00, 3'd6, 3'd1, 3'd1);
    stallIn = 1'b1;
    flush = 1'b1;
    #1 chk("flush stall", obs[0].idStall, 1);
    nextCycle();
    idle();
    #1 chk("flush ex bubble", obs[0].exValid, 0);
    chk("flush mem held", {obs[0].memValid, obs[0].memRead}, 2'b10);
    chk("flush wb held", obs[0].wbValid, 0);
    nextCycle();
    #1 chk("after flush wb", {obs[0].wbValid, obs[0].wbRegWrite,
                              obs[0].wbDest}, 5'b11101);

    // HALT with MEM_LAT=2
    doReset();
    drive(1'b1, 5'b00000, 2'b00, 3'd0, 3'd0, 3'd0);
    #1 chk("halt accept", obs[1].idStall, 0);
    for (int k = 1; k <= 6; k++) begin
      nextCycle();
      drive(1'b1, 5'b01000, 2'b00, 3'd3, 3'd4, 3'd4);
      #1;
      chk($sformatf("halted c%0d", k), obs[1].halted, (k >= 5));
      chk($sformatf("halt stall c%0d", k), obs[1].idStall, 1);
    end
    chk("halt ignores id", obs[1].exValid, 0);
    idle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    #1 chk("rst clears halted", {obs[1].halted, obs[1].idStall}, 0);

    // reset with LD in MEM
    doReset();
    drive(1'b1, 5'b10001, 2'b00, 3'd1, 3'd2, 3'd2);
    nextCycle();
    idle();
    nextCycle();
    #1 chk("ld in mem", obs[0].memRead, 1);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("post-rst c%0d", k),
             {obs[0].memRead, obs[0].wbValid}, 0);
      nextCycle();
    end

    // randomized run against the model
    idle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) mStep(i);
    nextCycle();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      idValid = ($urandom_range(0, 3) != 0);
      idOp = 5'($urandom);
      if (idOp == 5'd0 && $urandom_range(0, 7) != 0) idOp = 5'd1;
      idFunct = 2'($urandom);
      idDest = 3'($urandom);
      idRs = 3'($urandom);
      idRt = 3'($urandom);
      stallIn = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      #1;
      for (int i = 0; i < 3; i++) begin
        e = expectOf(i, mStall(i));
        chk($sformatf("random c%0d dut%0d", c, i), obs[i], e);
      end
      for (int i = 0; i < 3; i++) mStep(i);
      nextCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
